// File: rtl/awgn_pkg.sv
// rtl/awgn_pkg.sv - shared sizing helpers and rounding/saturation for the AWGN channel
package awgn_pkg;

  function automatic int calc_sh(input int gain_w, input int noise_w, input int sig_w);
    return gain_w - 1 + noise_w - sig_w;
  endfunction

  function automatic int calc_acc_w(input int sig_w, input int win_log2);
    return 2 * sig_w + 1 + win_log2;
  endfunction

  // Round half-up by sh bits (sh=0 means no shift), then clamp to a signed out_w-bit range.
  function automatic logic signed [63:0] round_sat(
    input  logic signed [63:0] x,
    input  int                 sh,
    input  int                 out_w,
    output logic               sat
  );
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    r = x;
    if (sh > 0) r = (x + (64'sd1 <<< (sh - 1))) >>> sh;
    hi  = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo  = -hi - 64'sd1;
    sat = 1'b0;
    if (r > hi) begin
      r   = hi;
      sat = 1'b1;
    end else if (r < lo) begin
      r   = lo;
      sat = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/awgn_channel_mux_if.sv
// rtl/awgn_channel_mux_if.sv - sample stream into and out of the AWGN channel
interface awgn_channel_mux_if #(
  parameter int SIG_W   = 18,
  parameter int NOISE_W = 20,
  parameter int OUT_W   = 19
);
  logic                      in_valid;
  logic signed [SIG_W-1:0]   i_sig;
  logic signed [SIG_W-1:0]   q_sig;
  logic signed [NOISE_W-1:0] i_noise;
  logic signed [NOISE_W-1:0] q_noise;
  logic                      out_valid;
  logic signed [OUT_W-1:0]   i_out;
  logic signed [OUT_W-1:0]   q_out;
  logic signed [SIG_W-1:0]   i_noise_sc;
  logic signed [SIG_W-1:0]   q_noise_sc;

  modport master (
    output in_valid, i_sig, q_sig, i_noise, q_noise,
    input  out_valid, i_out, q_out, i_noise_sc, q_noise_sc
  );

  modport slave (
    input  in_valid, i_sig, q_sig, i_noise, q_noise,
    output out_valid, i_out, q_out, i_noise_sc, q_noise_sc
  );
endinterface

// File: rtl/awgn_noise_scale.sv
// rtl/awgn_noise_scale.sv - S1 gain multiply and S2 round/saturate for one noise rail
module awgn_noise_scale
  import awgn_pkg::*;
#(
  parameter int SIG_W   = 18,
  parameter int NOISE_W = 20,
  parameter int GAIN_W  = 16
) (
  input  logic                      clk_fs,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic                      mid_valid,
  input  logic                      noise_en,
  input  logic [GAIN_W-1:0]         gain,
  input  logic signed [NOISE_W-1:0] noise,
  output logic signed [SIG_W-1:0]   noise_sc,
  output logic                      sat
);
  localparam int SH  = calc_sh(GAIN_W, NOISE_W, SIG_W);
  localparam int P_W = NOISE_W + GAIN_W + 1;

  logic signed [P_W-1:0]  prod;
  logic signed [GAIN_W:0] gain_s;
  logic signed [63:0]     rs;
  logic                   rs_sat;
  logic                   unused_rs;

  assign gain_s    = {1'b0, gain};
  assign unused_rs = ^rs[63:SIG_W];

  always_comb begin
    rs_sat = 1'b0;
    rs     = round_sat(64'(prod), SH, SIG_W, rs_sat);
  end

  always_ff @(posedge clk_fs or negedge rst_n) begin
    if (!rst_n) begin
      prod     <= '0;
      noise_sc <= '0;
      sat      <= 1'b0;
    end else begin
      if (in_valid) prod <= noise_en ? P_W'(noise) * P_W'(gain_s) : '0;
      if (mid_valid) noise_sc <= SIG_W'(rs);
      sat <= mid_valid & rs_sat;
    end
  end
endmodule

// File: rtl/awgn_channel_mux.sv
// rtl/awgn_channel_mux.sv - AWGN channel: gain shadow, noise scaling, saturating add, noise power meter
module awgn_channel_mux
  import awgn_pkg::*;
#(
  parameter int              SIG_W        = 18,
  parameter int              NOISE_W      = 20,
  parameter int              GAIN_W       = 16,
  parameter int              OUT_W        = 19,
  parameter logic [GAIN_W-1:0] GAIN_RST   = GAIN_W'(1) << (GAIN_W - 1),
  parameter int              PWR_WIN_LOG2 = 10
) (
  input  logic                 clk_fs,
  input  logic                 rst_n,
  input  logic [GAIN_W-1:0]    gain_in,
  input  logic                 gain_load,
  input  logic                 noise_en,
  input  logic                 sat_clr,
  awgn_channel_mux_if.slave    bus,
  output logic [GAIN_W-1:0]    gain_active,
  output logic                 sat_flag,
  output logic [2*SIG_W:0]     noise_pwr,
  output logic                 pwr_valid
);
  localparam int ACC_W = calc_acc_w(SIG_W, PWR_WIN_LOG2);
  localparam int PWR_W = 2 * SIG_W + 1;

  logic [GAIN_W-1:0]       gain_pend;
  logic [GAIN_W-1:0]       gain_eff;
  logic                    pend_flag;
  logic                    apply_pend;
  logic                    v1;
  logic                    v2;
  logic signed [SIG_W-1:0] i_sig1, q_sig1, i_sig2, q_sig2;
  logic signed [SIG_W-1:0] i_sc, q_sc;
  logic                    sat_i, sat_q;
  logic signed [SIG_W:0]   i_sum, q_sum;
  logic signed [63:0]      i_fit, q_fit;
  logic                    clip_i, clip_q, sat_set;
  logic                    unused_fit;

  // A pending gain is bypassed into S1 on the sample that commits it, so no sample sees a mix.
  assign apply_pend = bus.in_valid && pend_flag;
  assign gain_eff   = apply_pend ? gain_pend : gain_active;

  always_ff @(posedge clk_fs or negedge rst_n) begin
    if (!rst_n) begin
      gain_active <= GAIN_RST;
      gain_pend   <= GAIN_RST;
      pend_flag   <= 1'b0;
    end else begin
      if (apply_pend) gain_active <= gain_pend;
      if (gain_load) begin
        gain_pend <= gain_in;
        pend_flag <= 1'b1;
      end else if (bus.in_valid) begin
        pend_flag <= 1'b0;
      end
    end
  end

  awgn_noise_scale #(.SIG_W(SIG_W), .NOISE_W(NOISE_W), .GAIN_W(GAIN_W)) u_scale_i (
    .clk_fs(clk_fs), .rst_n(rst_n), .in_valid(bus.in_valid), .mid_valid(v1),
    .noise_en(noise_en), .gain(gain_eff), .noise(bus.i_noise), .noise_sc(i_sc), .sat(sat_i)
  );

  awgn_noise_scale #(.SIG_W(SIG_W), .NOISE_W(NOISE_W), .GAIN_W(GAIN_W)) u_scale_q (
    .clk_fs(clk_fs), .rst_n(rst_n), .in_valid(bus.in_valid), .mid_valid(v1),
    .noise_en(noise_en), .gain(gain_eff), .noise(bus.q_noise), .noise_sc(q_sc), .sat(sat_q)
  );

  // With OUT_W = SIG_W+1 the sum always fits, so the clamp below can only fire when OUT_W = SIG_W.
  always_comb begin
    i_sum   = (SIG_W+1)'(i_sig2) + (SIG_W+1)'(i_sc);
    q_sum   = (SIG_W+1)'(q_sig2) + (SIG_W+1)'(q_sc);
    clip_i  = 1'b0;
    clip_q  = 1'b0;
    i_fit   = round_sat(64'(i_sum), 0, OUT_W, clip_i);
    q_fit   = round_sat(64'(q_sum), 0, OUT_W, clip_q);
    sat_set = v2 && (sat_i || sat_q || clip_i || clip_q);
  end

  assign unused_fit = ^{i_fit[63:OUT_W], q_fit[63:OUT_W]};

  always_ff @(posedge clk_fs or negedge rst_n) begin
    if (!rst_n) begin
      v1             <= 1'b0;
      v2             <= 1'b0;
      i_sig1         <= '0;
      q_sig1         <= '0;
      i_sig2         <= '0;
      q_sig2         <= '0;
      bus.out_valid  <= 1'b0;
      bus.i_out      <= '0;
      bus.q_out      <= '0;
      bus.i_noise_sc <= '0;
      bus.q_noise_sc <= '0;
      sat_flag       <= 1'b0;
    end else begin
      v1            <= bus.in_valid;
      v2            <= v1;
      bus.out_valid <= v2;
      if (bus.in_valid) begin
        i_sig1 <= bus.i_sig;
        q_sig1 <= bus.q_sig;
      end
      if (v1) begin
        i_sig2 <= i_sig1;
        q_sig2 <= q_sig1;
      end
      if (v2) begin
        bus.i_out      <= OUT_W'(i_fit);
        bus.q_out      <= OUT_W'(q_fit);
        bus.i_noise_sc <= i_sc;
        bus.q_noise_sc <= q_sc;
      end
      if (sat_set) sat_flag <= 1'b1;
      else if (sat_clr) sat_flag <= 1'b0;
    end
  end

  logic [ACC_W-1:0]          acc;
  logic [ACC_W-1:0]          acc_next;
  logic [PWR_WIN_LOG2-1:0]   cnt;
  logic signed [2*SIG_W-1:0] i_sq, q_sq;
  logic [PWR_W-1:0]          term;

  assign i_sq     = (2*SIG_W)'(bus.i_noise_sc) * (2*SIG_W)'(bus.i_noise_sc);
  assign q_sq     = (2*SIG_W)'(bus.q_noise_sc) * (2*SIG_W)'(bus.q_noise_sc);
  assign term     = PWR_W'($unsigned(i_sq)) + PWR_W'($unsigned(q_sq));
  assign acc_next = acc + ACC_W'(term);

  always_ff @(posedge clk_fs or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      cnt       <= '0;
      noise_pwr <= '0;
      pwr_valid <= 1'b0;
    end else begin
      pwr_valid <= 1'b0;
      if (bus.out_valid) begin
        cnt <= cnt + PWR_WIN_LOG2'(1);
        if (&cnt) begin
          noise_pwr <= PWR_W'(acc_next >> PWR_WIN_LOG2);
          pwr_valid <= 1'b1;
          acc       <= '0;
        end else begin
          acc <= acc_next;
        end
      end
    end
  end
endmodule
